// File: rtl/alu_result_sel_reg.sv
// Registered ALU result-select: picks one of NUM_IN channels by a dense code, flags zero/illegal.
// Latency 1 cycle from accept to out_valid; err_cnt updates at accept time.
// Backpressure: in_ready = !out_valid || out_ready; with ALU_RESULT_SEL_SKID_EN, a skid entry makes in_ready a flop.
module alu_result_sel_reg #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 11,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_zero,
  output logic                    out_illegal,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        err_cnt,
  input  logic                    cnt_clr
);

  // One registered result: data plus the flags that travel with it.
  typedef struct packed {
    logic [WIDTH-1:0] dat;
    logic             zero;
    logic             ill;
  } ent_t;

  ent_t             w_new;
  logic             w_acc;
  logic             w_xfer;
  ent_t             r_out;
  logic             r_out_vld;
  logic [CNT_W-1:0] r_cnt;

  // Dense select: code k < NUM_IN picks channel k, anything else yields zero data flagged illegal.
  always_comb begin
    w_new.dat = '0;
    w_new.ill = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if ({1'b0, in_sel} == (SEL_W+1)'(k)) begin
        w_new.dat = in_data[k*WIDTH +: WIDTH];
        w_new.ill = 1'b0;
      end
    end
    w_new.zero = (w_new.dat == '0);
  end

  assign w_acc  = in_valid && in_ready;
  assign w_xfer = r_out_vld && out_ready;

`ifdef ALU_RESULT_SEL_SKID_EN
  ent_t r_skd;
  logic r_skd_vld;

  assign in_ready = !r_skd_vld;

  // Output register refills from the skid first so order is kept; a stalled accept parks in the skid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out     <= '0;
      r_out_vld <= 1'b0;
      r_skd     <= '0;
      r_skd_vld <= 1'b0;
    end else if (!r_out_vld || w_xfer) begin
      if (r_skd_vld) begin
        r_out     <= r_skd;
        r_out_vld <= 1'b1;
        r_skd_vld <= 1'b0;
      end else if (w_acc) begin
        r_out     <= w_new;
        r_out_vld <= 1'b1;
      end else begin
        r_out_vld <= 1'b0;
      end
    end else if (w_acc) begin
      r_skd     <= w_new;
      r_skd_vld <= 1'b1;
    end
  end
`else
  assign in_ready = !r_out_vld || out_ready;

  // Single output register: load on accept (also during a drain), otherwise drop valid once consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out     <= '0;
      r_out_vld <= 1'b0;
    end else if (w_acc) begin
      r_out     <= w_new;
      r_out_vld <= 1'b1;
    end else if (w_xfer) begin
      r_out_vld <= 1'b0;
    end
  end
`endif

  // Saturating count of accepted illegal selects; clear beats a same-cycle illegal accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_acc && w_new.ill && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_data    = r_out.dat;
  assign out_zero    = r_out.zero;
  assign out_illegal = r_out.ill;
  assign out_valid   = r_out_vld;
  assign err_cnt     = r_cnt;

endmodule

// File: tb/tb_alu_result_sel_reg.sv
// Bench for alu_result_sel_reg: directed steps then random traffic against a queue-based model.
// Two instances share the stimulus; the second uses a 2-bit counter to reach saturation quickly.
// Checks are sampled 1 time unit after the rising edge; in_ready is checked before the edge.
module tb_alu_result_sel_reg;

`ifdef ALU_RESULT_SEL_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam int NUM_IN = 11;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, cnt_clr;
  logic [3:0]  in_sel;
  logic [87:0] in_data;
  logic [7:0]  chan [NUM_IN];

  logic        in_ready, out_zero, out_illegal, out_valid;
  logic [7:0]  out_data, err_cnt;
  logic        s_in_ready, s_out_zero, s_out_illegal, s_out_valid;
  logic [7:0]  s_out_data;
  logic [1:0]  s_err_cnt;

  // Model state
  logic [8:0]  q [$];
  logic [8:0]  last;
  logic        last_z;
  int          cnt, cnt2;
  logic        exp_rdy, took, started;
  int          n_tests, n_fail;
  logic        pend, rv, iv, ordy, clr;
  logic [3:0]  sel;

  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    for (int k = 0; k < NUM_IN; k++) in_data[k*8 +: 8] = chan[k];
  end

  alu_result_sel_reg u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_zero(out_zero), .out_illegal(out_illegal),
    .out_valid(out_valid), .out_ready(out_ready), .err_cnt(err_cnt), .cnt_clr(cnt_clr)
  );

  alu_result_sel_reg #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(s_in_ready), .out_data(s_out_data), .out_zero(s_out_zero), .out_illegal(s_out_illegal),
    .out_valid(s_out_valid), .out_ready(out_ready), .err_cnt(s_err_cnt), .cnt_clr(cnt_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Expected selection result: {illegal, data}.
  function automatic logic [8:0] pick();
    int s;
    s = int'(in_sel);
    if (s < NUM_IN) return {1'b0, chan[s]};
    return 9'h100;
  endfunction

  task automatic step(input logic r, input logic v, input logic [3:0] s, input logic o, input logic c);
    logic [8:0] e;
    logic       acc, xfer;
    rst_n = r; in_valid = v; in_sel = s; out_ready = o; cnt_clr = c;
    #1;
    exp_rdy = (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || o);
    if (started) begin
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("sat_in_ready", 32'(s_in_ready), 32'(exp_rdy));
    end
    e = pick();
    @(posedge clk);
    took = 1'b0;
    if (!r) begin
      q.delete();
      last = '0; last_z = 1'b0; cnt = 0; cnt2 = 0; started = 1'b1;
    end else begin
      acc  = v && exp_rdy;
      xfer = (q.size() > 0) && o;
      took = acc;
      if (xfer) void'(q.pop_front());
      if (acc) q.push_back(e);
      if (c) begin
        cnt = 0; cnt2 = 0;
      end else if (acc && e[8]) begin
        if (cnt < 255) cnt++;
        if (cnt2 < 3) cnt2++;
      end
      if (q.size() > 0) begin
        last   = q[0];
        last_z = (q[0][7:0] == 8'h00);
      end
    end
    #1;
    if (started) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("out_data", 32'(out_data), 32'(last[7:0]));
      chk("out_zero", 32'(out_zero), 32'(last_z));
      chk("out_illegal", 32'(out_illegal), 32'(last[8]));
      chk("err_cnt", 32'(err_cnt), 32'(cnt));
      chk("sat_err_cnt", 32'(s_err_cnt), 32'(cnt2));
      chk("sat_out_data", 32'(s_out_data), 32'(last[7:0]));
      chk("sat_out_valid", 32'(s_out_valid), 32'(q.size() > 0));
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; started = 1'b0; pend = 1'b0; took = 1'b0;
    last = '0; last_z = 1'b0; cnt = 0; cnt2 = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; out_ready = 1'b0; cnt_clr = 1'b0;
    for (int k = 0; k < NUM_IN; k++) chan[k] = 8'(k * 16 + 1);
    @(posedge clk);

    // Reset held two cycles with a valid source
    step(1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'h00);
    chk("rst_cnt", 32'(err_cnt), 32'd0);

    // Basic select and zero flag
    chan[3] = 8'hA5;
    step(1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
    chk("basic_data", 32'(out_data), 32'hA5);
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_zero", 32'(out_zero), 32'd0);
    chan[0] = 8'h00;
    step(1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
    chk("zero_flag", 32'(out_zero), 32'd1);

    // Illegal selects and counter clear
    step(1'b1, 1'b1, 4'd11, 1'b1, 1'b0);
    chk("ill11", 32'(out_illegal), 32'd1);
    step(1'b1, 1'b1, 4'd15, 1'b1, 1'b0);
    chk("ill15_zero", 32'(out_zero), 32'd1);
    chk("ill_cnt2", 32'(err_cnt), 32'd2);
    step(1'b1, 1'b1, 4'd12, 1'b1, 1'b1);
    chk("clr_wins", 32'(err_cnt), 32'd0);

    // Saturation of the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 4'd13, 1'b1, 1'b0);
      if (i == 2) chk("sat_at3", 32'(s_err_cnt), 32'd3);
    end
    chk("sat_hold", 32'(s_err_cnt), 32'd3);
    chk("cnt_wide5", 32'(err_cnt), 32'd5);

    // Backpressure hold and zero-bubble drain+refill
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    chan[5] = 8'h3C;
    step(1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 4'd5, 1'b0, 1'b0);
      chk("bp_hold", 32'(out_data), 32'h3C);
`ifndef ALU_RESULT_SEL_SKID_EN
      chk("bp_rdy", 32'(in_ready), 32'd0);
`endif
    end
    chan[6] = 8'h77;
    step(1'b1, 1'b1, 4'd6, 1'b1, 1'b0);
    chk("no_bubble", 32'(out_data), 32'h77);

`ifdef ALU_RESULT_SEL_SKID_EN
    // Skid fill, ordered drain, reset drop
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    chan[1] = 8'h11; chan[2] = 8'h22;
    step(1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd2, 1'b0, 1'b0);
    chk("skid_head", 32'(out_data), 32'h11);
    chk("skid_full", 32'(in_ready), 32'd0);
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    chk("skid_second", 32'(out_data), 32'h22);
    step(1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("skid_rst", 32'(out_valid), 32'd0);
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    chk("skid_rst_empty", 32'(out_valid), 32'd0);
`endif

    // Random traffic; source holds data/select while stalled
    pend = 1'b0; sel = 4'd0;
    for (int n = 0; n < 600; n++) begin
      rv   = ($urandom_range(63) != 0);
      ordy = ($urandom_range(3) != 0);
      clr  = ($urandom_range(15) == 0);
      if (pend) begin
        iv = 1'b1;
      end else begin
        iv  = ($urandom_range(3) != 0);
        sel = 4'($urandom_range(15));
        for (int k = 0; k < NUM_IN; k++)
          chan[k] = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
      end
      step(rv, iv, sel, ordy, clr);
      pend = rv && iv && !took;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
